signal_measure_engine: RTL and testbench



---
 rtl/signal_measure_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_signal_measure_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_measure_engine.sv
// Multi-channel frequency/duty/period measurement engine. All results are
// produced by one shared restoring divider, one quotient bit per cycle.
module signal_measure_engine #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned DIV_W       = 40,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [7:0]        avg_n,
  input  logic              edge_sel,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       freq,
  output logic [6:0]        duty,
  output logic [CNT_W-1:0]  high_time,
  output logic [CNT_W-1:0]  low_time,
  output logic [CNT_W-1:0]  period
);

  localparam int unsigned SUM_W = CNT_W + 8;
  localparam int unsigned BC_W  = $clog2(DIV_W);

  typedef enum logic [2:0] {IDLE, ARM, MEAS, DIV, FIN} state_t;
  state_t state, state_nx;

  logic [NUM_CH-1:0] sync1, sync2;
  logic [SEL_W-1:0]  ch_lat;
  logic [7:0]        avg_lat;
  logic              edge_lat;
  logic              s, s_d, qual;

  logic [CNT_W-1:0]  pcnt, hcnt;
  logic [7:0]        n;
  logic [SUM_W-1:0]  sum_p, sum_h;

  logic [DIV_W-1:0]  dq, rem;
  logic [BC_W-1:0]   bcnt;
  logic [2:0]        didx;
  logic [31:0]       sh_freq;
  logic [6:0]        sh_duty;
  logic [CNT_W-1:0]  sh_high, sh_low;

  logic              tmo_hit, last_step;
  logic              start_acc, tmo_ev, first_ev, acc_ev, cnt_ev, div_ev;

  assign s         = sync2[ch_lat];
  assign qual      = edge_lat ? (~s & s_d) : (s & ~s_d);
  assign tmo_hit   = (pcnt == CNT_W'(TIMEOUT_CYC));
  assign last_step = (bcnt == BC_W'(DIV_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    tmo_ev    = 1'b0;
    first_ev  = 1'b0;
    acc_ev    = 1'b0;
    cnt_ev    = 1'b0;
    div_ev    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = ARM;
        end
      end
      ARM: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (tmo_hit) begin
          tmo_ev   = 1'b1;
          state_nx = FIN;
        end else if (qual) begin
          first_ev = 1'b1;
          state_nx = MEAS;
        end else begin
          cnt_ev = 1'b1;
        end
      end
      MEAS: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else if (qual) begin
          acc_ev = 1'b1;
          if (8'(n + 8'd1) == avg_lat) state_nx = DIV;
        end else if (tmo_hit) begin
          tmo_ev   = 1'b1;
          state_nx = FIN;
        end else begin
          cnt_ev = 1'b1;
        end
      end
      DIV: begin
        busy = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else begin
          div_ev = 1'b1;
          if (last_step && didx == 3'd4) state_nx = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Divider operand selection and one restoring step
  logic [DIV_W-1:0] dvd, dvs, cur_dq, cur_rem, rem_nx, q_nx;
  logic [DIV_W:0]   trial;
  logic             qbit;

  always_comb begin
    dvd = '0;
    dvs = DIV_W'(avg_lat);
    case (didx)
      3'd0: begin
        dvd = DIV_W'(CLK_FREQ) * DIV_W'(avg_lat);
        dvs = DIV_W'(sum_p);
      end
      3'd1: begin
        dvd = DIV_W'(sum_h) * DIV_W'(100);
        dvs = DIV_W'(sum_p);
      end
      3'd2:    dvd = DIV_W'(sum_h);
      3'd3:    dvd = DIV_W'(sum_p - sum_h);
      default: dvd = DIV_W'(sum_p);
    endcase
    cur_dq  = (bcnt == '0) ? dvd : dq;
    cur_rem = (bcnt == '0) ? '0 : rem;
    trial   = {cur_rem, cur_dq[DIV_W-1]} - {1'b0, dvs};
    qbit    = ~trial[DIV_W];
    rem_nx  = qbit ? trial[DIV_W-1:0] : {cur_rem[DIV_W-2:0], cur_dq[DIV_W-1]};
    q_nx    = {cur_dq[DIV_W-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      s_d       <= 1'b0;
      ch_lat    <= '0;
      avg_lat   <= 8'd1;
      edge_lat  <= 1'b0;
      pcnt      <= '0;
      hcnt      <= '0;
      n         <= '0;
      sum_p     <= '0;
      sum_h     <= '0;
      dq        <= '0;
      rem       <= '0;
      bcnt      <= '0;
      didx      <= '0;
      sh_freq   <= '0;
      sh_duty   <= '0;
      sh_high   <= '0;
      sh_low    <= '0;
      timeout   <= 1'b0;
      freq      <= '0;
      duty      <= '0;
      high_time <= '0;
      low_time  <= '0;
      period    <= '0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      // Reload s_d from the newly selected channel so switching cannot fake an edge
      s_d   <= start_acc ? sync2[ch_sel] : s;
      if (start_acc) begin
        ch_lat   <= ch_sel;
        avg_lat  <= (avg_n == 8'd0) ? 8'd1 : avg_n;
        edge_lat <= edge_sel;
        pcnt     <= '0;
        hcnt     <= '0;
        n        <= '0;
        sum_p    <= '0;
        sum_h    <= '0;
        bcnt     <= '0;
        didx     <= '0;
        timeout  <= 1'b0;
      end
      if (tmo_ev) timeout <= 1'b1;
      if (first_ev) begin
        pcnt <= CNT_W'(1);
        hcnt <= CNT_W'(s);
      end
      if (acc_ev) begin
        sum_p <= sum_p + SUM_W'(pcnt);
        sum_h <= sum_h + SUM_W'(hcnt);
        pcnt  <= CNT_W'(1);
        hcnt  <= CNT_W'(s);
        n     <= n + 8'd1;
      end
      if (cnt_ev) begin
        pcnt <= pcnt + CNT_W'(1);
        hcnt <= hcnt + CNT_W'(s);
      end
      if (div_ev) begin
        dq  <= q_nx;
        rem <= rem_nx;
        if (last_step) begin
          bcnt <= '0;
          didx <= didx + 3'd1;
          case (didx)
            3'd0: sh_freq <= q_nx[31:0];
            3'd1: sh_duty <= q_nx[6:0];
            3'd2: sh_high <= q_nx[CNT_W-1:0];
            3'd3: sh_low  <= q_nx[CNT_W-1:0];
            default: begin
              // Outputs load on the edge entering FIN so they coincide with done
              freq      <= sh_freq;
              duty      <= sh_duty;
              high_time <= sh_high;
              low_time  <= sh_low;
              period    <= q_nx[CNT_W-1:0];
            end
          endcase
        end else begin
          bcnt <= bcnt + BC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_signal_measure_engine.sv
// Scoreboard bench for signal_measure_engine: stimulus pushes predicted
// results, a negedge monitor pops and compares on every done pulse.
module tb_signal_measure_engine;

  localparam longint CLK_HZ = 50_000_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sig_in = '0;
  logic [1:0]  ch_sel = '0;
  logic [7:0]  avg_n = '0;
  logic        edge_sel = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, timeout;
  logic [31:0] freq;
  logic [6:0]  duty;
  logic [19:0] high_time, low_time, period;

  signal_measure_engine #(
    .CLK_FREQ(50_000_000), .NUM_CH(4), .CNT_W(20), .TIMEOUT_CYC(1000), .DIV_W(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_sel(ch_sel), .avg_n(avg_n),
    .edge_sel(edge_sel), .start(start), .abort(abort), .busy(busy), .done(done),
    .timeout(timeout), .freq(freq), .duty(duty), .high_time(high_time),
    .low_time(low_time), .period(period)
  );

  always #10 clk = ~clk;

  typedef struct {
    longint to, f, d, h, l, p;
  } exp_t;

  exp_t   sb[$];
  exp_t   last = '{0, 0, 0, 0, 0, 0};
  int     errors = 0;
  int     checks = 0;
  int     done_cnt = 0;
  int     per[4] = '{10, 10, 10, 10};
  int     hi[4]  = '{5, 5, 5, 5};
  int     wcnt[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: a steady wave of period p, high h averaged over N periods
  function automatic exp_t predict(input int p, input int h, input int avg);
    exp_t   r;
    longint nn = (avg == 0) ? 1 : avg;
    longint sp = nn * p;
    longint sh = nn * h;
    r.to = 0;
    r.f  = (CLK_HZ * nn) / sp;
    r.d  = (sh * 100) / sp;
    r.h  = sh / nn;
    r.l  = (sp - sh) / nn;
    r.p  = sp / nn;
    return r;
  endfunction

  // Periodic square waves, one counter per channel; hi=0 holds the input low
  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (wcnt[c] >= per[c]) wcnt[c] = 0;
        sig_in[c] = (wcnt[c] < hi[c]);
        wcnt[c]++;
      end
    end
  end

  initial begin
    exp_t e;
    bit   prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", prev_done, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending run");
        end else begin
          e = sb.pop_front();
          chk("timeout", timeout, e.to);
          chk("freq", freq, e.f);
          chk("duty", duty, e.d);
          chk("high_time", high_time, e.h);
          chk("low_time", low_time, e.l);
          chk("period", period, e.p);
          chk("busy_at_done", busy, 0);
        end
      end
      prev_done = done;
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic set_wave(input int c, input int p, input int h);
    per[c] = p;
    hi[c]  = h;
    cyc(5);
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      cyc(1);
      k++;
    end
    chk("run_finishes", busy, 0);
    cyc(2);
  endtask

  task automatic issue(input int c, input int avg, input bit es);
    ch_sel   = 2'(c);
    avg_n    = 8'(avg);
    edge_sel = es;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run(input int c, input int p, input int h, input int avg, input bit es);
    set_wave(c, p, h);
    last = predict(p, h, avg);
    sb.push_back(last);
    issue(c, avg, es);
    wait_idle(20000);
  endtask

  task automatic chk_unchanged(input string tag);
    chk({tag, "_freq"}, freq, last.f);
    chk({tag, "_duty"}, duty, last.d);
    chk({tag, "_period"}, period, last.p);
  endtask

  initial begin
    exp_t e;
    int   k, dc;
    #5;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_freq", freq, 0);
    chk("reset_period", period, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    run(0, 50, 15, 8, 1'b0);
    run(2, 7, 3, 0, 1'b0);

    // No-signal timeout on channel 3
    set_wave(3, 10, 0);
    e = last;
    e.to = 1;
    sb.push_back(e);
    issue(3, 4, 1'b0);
    k = 0;
    while (k < 1100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      #1;
      k++;
    end
    chk("timeout_latency", k, 1001);
    cyc(3);
    chk("timeout_holds", timeout, 1);

    // Settings changed and start re-pulsed mid-run
    dc = done_cnt;
    set_wave(1, 30, 12);
    last = predict(30, 12, 4);
    sb.push_back(last);
    issue(1, 4, 1'b0);
    chk("timeout_cleared_on_start", timeout, 0);
    cyc(20);
    ch_sel = 2'd2;
    avg_n = 8'd1;
    edge_sel = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_idle(20000);
    chk("single_done_midrun", done_cnt - dc, 1);

    run(0, 40, 10, 5, 1'b1);
    run(0, 40, 10, 5, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int p, h;
      p = $urandom_range(60, 2);
      h = $urandom_range(p - 1, 1);
      run($urandom_range(2, 0), p, h, $urandom_range(12, 0), 1'($urandom_range(1, 0)));
    end

    // Abort during MEAS, then during DIV
    for (int a = 0; a < 2; a++) begin
      dc = done_cnt;
      set_wave(1, 20, 5);
      issue(1, (a == 0) ? 10 : 1, 1'b0);
      cyc((a == 0) ? 40 : 70);
      chk("busy_before_abort", busy, 1);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("busy_after_abort", busy, 0);
      cyc(5);
      chk("no_done_on_abort", done_cnt - dc, 0);
      chk_unchanged("abort");
    end

    // Reset asserted mid-DIV
    issue(1, 1, 1'b0);
    cyc(70);
    chk("busy_in_div", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_freq", freq, 0);
    chk("rst_duty", duty, 0);
    chk("rst_high", high_time, 0);
    chk("rst_low", low_time, 0);
    chk("rst_period", period, 0);
    last = '{0, 0, 0, 0, 0, 0};
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    run(2, 13, 4, 3, 1'b1);
    cyc(5);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
